// File: rtl/decoder_rr_arbiter_4_if.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter_4_if
// Purpose : request/grant bundle between four requesters and the
//           round-robin arbiter that drives a 4-way decoded resource.
// Signals : ena       - arbiter enable (requester side drives)
//           req[3:0]  - level-sensitive request lines
//           gnt[3:0]  - one-hot grant, 4'b0000 when idle
//           gnt_valid - any grant active (|gnt)
//           gnt_id    - index of current/last owner
//           timeout   - one-cycle forced-release pulse (ARB_TIMEOUT_EN only)
// Macro   : ARB_TIMEOUT_EN adds the timeout signal.
// ---------------------------------------------------------------------------
interface decoder_rr_arbiter_4_if;
  logic       ena;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;

  modport master (output ena, req, input gnt, gnt_valid, gnt_id, timeout);
  modport slave  (input ena, req, output gnt, gnt_valid, gnt_id, timeout);
`else
  modport master (output ena, req, input gnt, gnt_valid, gnt_id);
  modport slave  (input ena, req, output gnt, gnt_valid, gnt_id);
`endif
endinterface

// File: rtl/decoder_rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter_4
// Purpose : round-robin arbiter sharing one 4-way decoded resource among
//           four requesters. A grant is held while its owner requests; on
//           release the priority pointer rotates to the next index and a
//           new winner is picked on the same edge (back-to-back grants).
//           The one-hot grant comes from a decoder_2_to_4 instance driven
//           by (state == GRANT) and gnt_id, so grant is purely registered.
// Ports   : clk_i - rising-edge clock
//           rst_i - asynchronous active-high reset
//           bus   - decoder_rr_arbiter_4_if.slave (ena, req, gnt,
//                   gnt_valid, gnt_id, timeout)
// Param   : TIMEOUT (2..255) - max consecutive hold cycles per owner,
//           only meaningful with ARB_TIMEOUT_EN.
// Macro   : ARB_TIMEOUT_EN - enables the hold counter and timeout pulse.
// ---------------------------------------------------------------------------
module decoder_2_to_4 (
  input  logic       ena_i,
  input  logic [1:0] in_i,
  output logic [3:0] out_o
);
  // Plain enabled 2-to-4 decode.
  always_comb begin
    out_o = 4'b0000;
    if (ena_i) begin
      case (in_i)
        2'd0:    out_o = 4'b0001;
        2'd1:    out_o = 4'b0010;
        2'd2:    out_o = 4'b0100;
        2'd3:    out_o = 4'b1000;
        default: out_o = 4'b0000;
      endcase
    end else begin
      out_o = 4'b0000;
    end
  end
endmodule

module decoder_rr_arbiter_4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  decoder_rr_arbiter_4_if.slave bus
);
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("decoder_rr_arbiter_4: TIMEOUT must be within 2..255");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [2:0] arb_s;       // {found, index}
  logic [1:0] next_ptr_s;  // owner + 1, wraps 3 -> 0
  logic [3:0] gnt_s;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // First requester found scanning p, p+1, p+2, p+3 (mod 4). Scanning the
  // offsets from high to low lets the smallest offset overwrite the result.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign next_ptr_s = gnt_id_q + 2'd1;

  decoder_2_to_4 u_dec (
    .ena_i (state_q == GRANT),
    .in_i  (gnt_id_q),
    .out_o (gnt_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_id_q  <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state logic: arbitration, hold, release, revoke.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    arb_s    = 3'b000;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        arb_s = arbitrate(bus.req, ptr_q);
        if (bus.ena && arb_s[2]) begin
          state_d  = GRANT;
          gnt_id_d = arb_s[1:0];
`ifdef ARB_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.ena) begin
          // Enable low overrides everything: revoke and rotate.
          state_d = IDLE;
          ptr_d   = next_ptr_s;
        end else if (bus.req[gnt_id_q]) begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q == HOLD_LAST) begin
            // Forced release: current owner (gnt_s) is excluded from the scan.
            ptr_d = next_ptr_s;
            cnt_d = 8'd0;
            arb_s = arbitrate(bus.req & ~gnt_s, next_ptr_s);
            if (arb_s[2]) begin
              gnt_id_d  = arb_s[1:0];
              timeout_d = 1'b1;
            end else begin
              gnt_id_d  = gnt_id_q;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`else
          state_d = GRANT;
`endif
        end else begin
          // Owner released: rotate and re-arbitrate on the same edge.
          ptr_d = next_ptr_s;
          arb_s = arbitrate(bus.req, next_ptr_s);
          if (arb_s[2]) begin
            gnt_id_d = arb_s[1:0];
`ifdef ARB_TIMEOUT_EN
            cnt_d    = 8'd0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs, all derived from registered state.
  always_comb begin
    bus.gnt       = gnt_s;
    bus.gnt_valid = |gnt_s;
    bus.gnt_id    = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
    bus.timeout   = timeout_q;
`endif
  end
endmodule

// File: tb/tb_decoder_rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// tb_decoder_rr_arbiter_4
// Purpose : self-checking bench for decoder_rr_arbiter_4. Directed
//           scenarios plus randomized traffic, every cycle compared to a
//           behavioural owner/pointer model.
// Macro   : ARB_TIMEOUT_EN enables the timeout scenarios (TIMEOUT = 4).
// ---------------------------------------------------------------------------
module tb_decoder_rr_arbiter_4;
  localparam int TO = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  decoder_rr_arbiter_4_if bus_if ();

  decoder_rr_arbiter_4 #(.TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_to;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    m_to = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!bus_if.ena) begin
      if (m_busy) begin
        m_ptr  = (m_owner + 1) % 4;
        m_busy = 1'b0;
      end
    end else if (!m_busy) begin
      w = pick(bus_if.req, m_ptr, -1);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_cnt = 0;
      end
    end else if (bus_if.req[m_owner]) begin
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == TO - 1) begin
        m_ptr = (m_owner + 1) % 4;
        m_cnt = 0;
        w = pick(bus_if.req, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w; m_to = 1'b1;
        end
      end else begin
        m_cnt++;
      end
`endif
    end else begin
      m_ptr = (m_owner + 1) % 4;
      w = pick(bus_if.req, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_cnt = 0;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] exp_gnt;
    exp_gnt = m_busy ? 4'(1 << m_owner) : 4'b0000;
    check_eq("gnt", 32'(bus_if.gnt), 32'(exp_gnt));
    check_eq("gnt_valid", 32'(bus_if.gnt_valid), 32'(m_busy));
    check_eq("gnt_id", 32'(bus_if.gnt_id), 32'(m_owner));
`ifdef ARB_TIMEOUT_EN
    check_eq("timeout", 32'(bus_if.timeout), 32'(m_to));
`endif
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    rst = 1'b0;
  endtask

  task automatic step_expect(input string tag, input logic [3:0] exp_gnt);
    step();
    check_eq(tag, 32'(bus_if.gnt), 32'(exp_gnt));
  endtask

  initial begin
    logic [3:0] r;
    n_checks = 0;
    n_fails  = 0;
    model_reset();
    rst = 1'b1;
    bus_if.ena = 1'b0;
    bus_if.req = 4'b0000;
    #2;
    check_eq("reset_gnt", 32'(bus_if.gnt), 32'h0);
    do_reset();
    check_eq("reset_gnt_id", 32'(bus_if.gnt_id), 32'h0);

    // Full rotation with wrap, no idle cycles.
    bus_if.ena = 1'b1;
    bus_if.req = 4'b1111; step_expect("rot0", 4'b0001);
    bus_if.req = 4'b1110; step_expect("rot1", 4'b0010);
    bus_if.req = 4'b1100; step_expect("rot2", 4'b0100);
    bus_if.req = 4'b1000; step_expect("rot3", 4'b1000);
    bus_if.req = 4'b0111; step_expect("rot_wrap", 4'b0001);
    bus_if.req = 4'b0000; step_expect("rot_idle", 4'b0000);

    // Sparse requests from ptr = 0, then idle holding last owner.
    do_reset();
    bus_if.req = 4'b1010; step_expect("sparse1", 4'b0010);
    check_eq("sparse1_id", 32'(bus_if.gnt_id), 32'd1);
    bus_if.req = 4'b1000; step_expect("sparse3", 4'b1000);
    bus_if.req = 4'b0000; step_expect("sparse_idle", 4'b0000);
    check_eq("idle_valid", 32'(bus_if.gnt_valid), 32'd0);
    check_eq("idle_id_hold", 32'(bus_if.gnt_id), 32'd3);

    // Owner 2 releases while requester 1 rises on the same cycle.
    bus_if.req = 4'b0100; step_expect("own2", 4'b0100);
    bus_if.req = 4'b0010; step_expect("same_cycle_req", 4'b0010);

    // Enable low revokes owner 1; re-enable scans from 2.
    bus_if.req = 4'b0011; bus_if.ena = 1'b0; step_expect("ena_revoke", 4'b0000);
    bus_if.ena = 1'b1; step_expect("ena_resume", 4'b0001);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model();
    check_eq("async_rst_gnt", 32'(bus_if.gnt), 32'h0);
    #1 rst = 1'b0;
    bus_if.req = 4'b1000; step_expect("post_rst", 4'b1000);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    bus_if.req = 4'b0001; step_expect("to_grant0", 4'b0001);
    bus_if.req = 4'b0011;
    repeat (3) step_expect("to_hold0", 4'b0001);
    step_expect("to_move1", 4'b0010);
    check_eq("to_pulse", 32'(bus_if.timeout), 32'd1);
    bus_if.req = 4'b0010; step();
    check_eq("to_pulse_end", 32'(bus_if.timeout), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step_expect("to_alone", 4'b0010);
      check_eq("to_alone_pulse", 32'(bus_if.timeout), 32'd0);
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 15));
      else r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
      bus_if.req = r;
      bus_if.ena = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
